// File: rtl/cpu_bus_router.sv
// Routes single CPU accesses to one of NUM_DEVICES ports by address[31:28], with
// per-access timeout and a sticky bus_error for unmapped or timed-out accesses.
module cpu_bus_router #(
  parameter int unsigned NUM_DEVICES = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_reset,
  input  logic                        i_cpu_request,
  input  logic [31:0]                 i_cpu_address,
  input  logic [31:0]                 i_cpu_wdata,
  input  logic [3:0]                  i_cpu_wmask,
  output logic                        o_cpu_ack,
  output logic [31:0]                 o_cpu_rdata,
  output logic [NUM_DEVICES-1:0]      o_dev_request,
  output logic [31:0]                 o_dev_address,
  output logic [31:0]                 o_dev_wdata,
  output logic [3:0]                  o_dev_wmask,
  input  logic [NUM_DEVICES-1:0]      i_dev_ack,
  input  logic [32*NUM_DEVICES-1:0]   i_dev_rdata,
  output logic                        o_bus_error,
  input  logic                        i_bus_error_clear
);

  typedef enum logic [1:0] {StIdle, StWait, StErrAck} state_e;

  state_e                 r_state, w_state_next;
  logic [3:0]             r_idx;
  logic [7:0]             r_cnt, w_cnt_next;
  logic [NUM_DEVICES-1:0] r_dev_request, w_dev_request_next;
  logic                   r_err_ack, w_err_ack_next;
  logic                   r_bus_error;
  logic [31:0]            r_dev_address, r_dev_wdata;
  logic [3:0]             r_dev_wmask;

  logic [3:0]             w_req_idx;
  logic                   w_mapped;
  logic                   w_accept;
  logic                   w_set_error;
  logic                   w_sel_ack;
  logic [31:0]            w_sel_rdata;
  logic                   w_timeout;

  assign w_req_idx = i_cpu_address[31:28];
  assign w_mapped  = ({1'b0, w_req_idx} < 5'(NUM_DEVICES));
  assign w_timeout = (r_cnt == 8'(TIMEOUT));

  // Only the latched device is visible; acks from any other port are dropped here.
  always_comb begin
    w_sel_ack   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (r_idx == 4'(i)) begin
        w_sel_ack   = i_dev_ack[i];
        w_sel_rdata = i_dev_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_dev_request_next = '0;
    w_err_ack_next     = 1'b0;
    w_set_error        = 1'b0;
    w_accept           = 1'b0;
    o_cpu_ack          = r_err_ack;
    o_cpu_rdata        = '0;
    unique case (r_state)
      StIdle: begin
        if (i_cpu_request) begin
          if (w_mapped) begin
            w_accept     = 1'b1;
            w_cnt_next   = '0;
            w_state_next = StWait;
            for (int i = 0; i < NUM_DEVICES; i++) begin
              w_dev_request_next[i] = (w_req_idx == 4'(i));
            end
          end else begin
            w_state_next = StErrAck;
          end
        end
      end
      StWait: begin
        // A device ack beats a timeout landing in the same cycle.
        if (w_sel_ack) begin
          o_cpu_ack    = 1'b1;
          o_cpu_rdata  = w_sel_rdata;
          w_state_next = StIdle;
        end else if (w_timeout) begin
          o_cpu_ack    = 1'b1;
          o_cpu_rdata  = 32'hFFFF_FFFF;
          w_set_error  = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      StErrAck: begin
        w_err_ack_next = 1'b1;
        w_set_error    = 1'b1;
        w_state_next   = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_dev_request <= '0;
      r_err_ack     <= 1'b0;
      r_bus_error   <= 1'b0;
      r_dev_address <= '0;
      r_dev_wdata   <= '0;
      r_dev_wmask   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_dev_request <= w_dev_request_next;
      r_err_ack     <= w_err_ack_next;
      if (w_accept) begin
        r_idx         <= w_req_idx;
        r_dev_address <= i_cpu_address;
        r_dev_wdata   <= i_cpu_wdata;
        r_dev_wmask   <= i_cpu_wmask;
      end
      if (w_set_error) begin
        r_bus_error <= 1'b1;
      end else if (i_bus_error_clear) begin
        r_bus_error <= 1'b0;
      end
    end
  end

  assign o_dev_request = r_dev_request;
  assign o_dev_address = r_dev_address;
  assign o_dev_wdata   = r_dev_wdata;
  assign o_dev_wmask   = r_dev_wmask;
  assign o_bus_error   = r_bus_error;

endmodule

// File: tb/tb_cpu_bus_router.sv
// Bench for cpu_bus_router: transaction-level model scheduling expected outputs per cycle,
// directed literal checks on recorded history, then randomized traffic.
module tb_cpu_bus_router;

  localparam int unsigned NDEV = 4;
  localparam int unsigned TMO  = 8;

  logic                 clk = 1'b0;
  logic                 rst, req, bclr;
  logic [31:0]          addr, wdata;
  logic [3:0]           wmask;
  logic                 ack;
  logic [31:0]          rdata;
  logic [NDEV-1:0]      dreq;
  logic [31:0]          daddr, dwdata;
  logic [3:0]           dwmask;
  logic [NDEV-1:0]      dack;
  logic [32*NDEV-1:0]   drdata;
  logic                 berr;

  cpu_bus_router #(.NUM_DEVICES(NDEV), .TIMEOUT(TMO)) dut (
    .i_sys_clk         (clk),
    .i_sys_reset       (rst),
    .i_cpu_request     (req),
    .i_cpu_address     (addr),
    .i_cpu_wdata       (wdata),
    .i_cpu_wmask       (wmask),
    .o_cpu_ack         (ack),
    .o_cpu_rdata       (rdata),
    .o_dev_request     (dreq),
    .o_dev_address     (daddr),
    .o_dev_wdata       (dwdata),
    .o_dev_wmask       (dwmask),
    .i_dev_ack         (dack),
    .i_dev_rdata       (drdata),
    .o_bus_error       (berr),
    .i_bus_error_clear (bclr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: expected events keyed by cycle number.
  logic [31:0]     m_ack_at    [int];
  logic [NDEV-1:0] m_dreq_at   [int];
  bit              m_errset_at [int];
  bit              m_clr_at    [int];
  bit              m_rst_at    [int];
  logic [67:0]     m_upd_at    [int];
  logic            m_err  = 1'b0;
  logic [67:0]     m_regs = '0;

  // Observed DUT outputs per cycle, used by the directed literal checks.
  logic            h_ack    [int];
  logic [31:0]     h_rdata  [int];
  logic [NDEV-1:0] h_dreq   [int];
  logic            h_err    [int];
  logic [31:0]     h_daddr  [int];
  logic [31:0]     h_dwdata [int];
  logic [3:0]      h_dwmask [int];

  int n_cmp  = 0;
  int n_fail = 0;
  bit clr_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
    end
  endtask

  logic            e_ack;
  logic [31:0]     e_rdata;
  logic [NDEV-1:0] e_dreq;

  initial forever begin
    @(negedge clk);
    if (m_rst_at.exists(cyc)) begin
      m_err  = 1'b0;
      m_regs = '0;
    end else begin
      if (m_errset_at.exists(cyc)) m_err = 1'b1;
      else if (m_clr_at.exists(cyc - 1)) m_err = 1'b0;
      if (m_upd_at.exists(cyc)) m_regs = m_upd_at[cyc];
    end
    e_ack   = m_ack_at.exists(cyc);
    e_rdata = e_ack ? m_ack_at[cyc] : 32'h0;
    e_dreq  = m_dreq_at.exists(cyc) ? m_dreq_at[cyc] : '0;
    chk("cpu_ack", 32'(ack), 32'(e_ack));
    chk("cpu_rdata", rdata, e_rdata);
    chk("dev_request", 32'(dreq), 32'(e_dreq));
    chk("bus_error", 32'(berr), 32'(m_err));
    chk("dev_address", daddr, m_regs[67:36]);
    chk("dev_wdata", dwdata, m_regs[35:4]);
    chk("dev_wmask", 32'(dwmask), 32'(m_regs[3:0]));
    h_ack[cyc]    = ack;
    h_rdata[cyc]  = rdata;
    h_dreq[cyc]   = dreq;
    h_err[cyc]    = berr;
    h_daddr[cyc]  = daddr;
    h_dwdata[cyc] = dwdata;
    h_dwmask[cyc] = dwmask;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Defaults for a cycle: random acks on every device except tgt, random read data.
  task automatic drive_common(input int tgt);
    rst = 1'b0;
    req = 1'b0;
    for (int i = 0; i < NDEV; i++) begin
      dack[i] = (i != tgt) && ($urandom_range(0, 2) == 0);
      drdata[32*i +: 32] = $urandom();
    end
    bclr = clr_en && ($urandom_range(0, 5) == 0);
    if (bclr) m_clr_at[cyc] = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive_common(-1);
      next_cycle();
    end
  endtask

  task automatic model_reset(input int c);
    int ks[$];
    foreach (m_ack_at[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) m_ack_at.delete(ks[i]);
    ks.delete();
    foreach (m_dreq_at[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) m_dreq_at.delete(ks[i]);
    ks.delete();
    foreach (m_errset_at[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) m_errset_at.delete(ks[i]);
    ks.delete();
    foreach (m_upd_at[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) m_upd_at.delete(ks[i]);
    m_rst_at[c + 1] = 1'b1;
  endtask

  // One CPU access. d: device ack comes d cycles after its dev_request. late: after a
  // timeout, the device still acks 3 cycles later. rst_off >= 0: reset that many cycles
  // after dev_request.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                         input int d, input bit late, input int rst_off,
                         input logic [31:0] rd, output int n);
    int tgt, ack_c, tmo_c, end_c, last_c, rst_c;
    n     = cyc;
    tgt   = int'(a[31:28]);
    rst_c = (rst_off >= 0) ? n + 1 + rst_off : -1;
    if (tgt >= NDEV) begin
      m_ack_at[n + 2]    = 32'h0;
      m_errset_at[n + 2] = 1'b1;
      tgt    = -1;
      ack_c  = -1;
      end_c  = n + 1;
      last_c = n + 2;
    end else begin
      m_dreq_at[n + 1] = NDEV'(1) << tgt;
      m_upd_at[n + 1]  = {a, wd, wm};
      ack_c = n + 1 + d;
      tmo_c = n + 1 + TMO;
      if (ack_c <= tmo_c) begin
        m_ack_at[ack_c] = rd;
        end_c  = ack_c;
        last_c = ack_c;
      end else begin
        m_ack_at[tmo_c]        = 32'hFFFF_FFFF;
        m_errset_at[tmo_c + 1] = 1'b1;
        end_c  = tmo_c;
        last_c = late ? tmo_c + 3 : tmo_c;
        ack_c  = late ? tmo_c + 3 : -1;
      end
    end
    for (int c = n; c <= last_c; c++) begin
      drive_common(tgt);
      addr  = a;
      wdata = wd;
      wmask = wm;
      if (c == n) req = 1'b1;
      else if (c <= end_c && (rst_c < 0 || c <= rst_c)) req = ($urandom_range(0, 3) == 0);
      if (c == rst_c) begin
        rst = 1'b1;
        model_reset(c);
      end
      if (tgt >= 0 && c == ack_c) begin
        dack[tgt] = 1'b1;
        drdata[32*tgt +: 32] = rd;
      end
      next_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, required < 100000", cyc);
    $fatal(1);
  end

  initial begin
    int n, n2, c, idx, d, ro;
    rst = 1'b1; req = 1'b0; bclr = 1'b0;
    addr = '0; wdata = '0; wmask = '0; dack = '0; drdata = '0;
    m_rst_at[1] = 1'b1;
    m_rst_at[2] = 1'b1;
    next_cycle();
    next_cycle();
    idle(2);
    chk("reset cpu_ack", 32'(h_ack[2]), 32'h0);
    chk("reset dev_request", 32'(h_dreq[2]), 32'h0);
    chk("reset bus_error", 32'(h_err[2]), 32'h0);
    chk("reset dev_address", h_daddr[2], 32'h0);

    // Read from device 1, one-cycle device latency.
    run_txn(32'h1000_0004, 32'h0, 4'h0, 1, 1'b0, -1, 32'h1234_5678, n);
    chk("rd dev_request N+1", 32'(h_dreq[n + 1]), 32'h2);
    chk("rd dev_request N+2", 32'(h_dreq[n + 2]), 32'h0);
    chk("rd cpu_ack N+1", 32'(h_ack[n + 1]), 32'h0);
    chk("rd cpu_ack N+2", 32'(h_ack[n + 2]), 32'h1);
    chk("rd cpu_rdata N+2", h_rdata[n + 2], 32'h1234_5678);
    idle(1);

    // Write to device 0.
    run_txn(32'h0000_0010, 32'hAABB_CCDD, 4'hF, 2, 1'b0, -1, 32'h0, n);
    chk("wr dev_address held N", h_daddr[n], 32'h1000_0004);
    chk("wr dev_address N+1", h_daddr[n + 1], 32'h0000_0010);
    chk("wr dev_wdata N+1", h_dwdata[n + 1], 32'hAABB_CCDD);
    chk("wr dev_wmask N+1", 32'(h_dwmask[n + 1]), 32'hF);
    idle(1);

    // Unmapped access, then explicit error clear.
    run_txn(32'h5000_0000, 32'h0, 4'h0, 1, 1'b0, -1, 32'h0, n);
    chk("unm dev_request N+1", 32'(h_dreq[n + 1]), 32'h0);
    chk("unm cpu_ack N+2", 32'(h_ack[n + 2]), 32'h1);
    chk("unm cpu_rdata N+2", h_rdata[n + 2], 32'h0);
    chk("unm bus_error N+2", 32'(h_err[n + 2]), 32'h1);
    idle(3);
    drive_common(-1);
    bclr = 1'b1;
    m_clr_at[cyc] = 1'b1;
    c = cyc;
    next_cycle();
    idle(1);
    chk("clr bus_error before", 32'(h_err[c]), 32'h1);
    chk("clr bus_error after", 32'(h_err[c + 1]), 32'h0);

    // Timeout with a late ack three cycles later.
    run_txn(32'h2000_0000, 32'h0, 4'h0, 20, 1'b1, -1, 32'hDEAD_BEEF, n);
    chk("tmo cpu_ack N+8", 32'(h_ack[n + 8]), 32'h0);
    chk("tmo cpu_ack N+9", 32'(h_ack[n + 9]), 32'h1);
    chk("tmo cpu_rdata N+9", h_rdata[n + 9], 32'hFFFF_FFFF);
    chk("tmo bus_error N+9", 32'(h_err[n + 9]), 32'h0);
    chk("tmo bus_error N+10", 32'(h_err[n + 10]), 32'h1);
    chk("late ack ignored", 32'(h_ack[n + 12]), 32'h0);
    idle(1);

    // Reset inside WAIT, then the device acks anyway; then a normal access.
    run_txn(32'h3000_0040, 32'h1111_2222, 4'h3, 5, 1'b0, 2, 32'h5555_AAAA, n);
    chk("rstw cpu_ack", 32'(h_ack[n + 6]), 32'h0);
    chk("rstw cpu_rdata", h_rdata[n + 6], 32'h0);
    chk("rstw dev_address", h_daddr[n + 4], 32'h0);
    chk("rstw bus_error", 32'(h_err[n + 4]), 32'h0);
    run_txn(32'h3000_0000, 32'h0, 4'h0, 1, 1'b0, -1, 32'h0BAD_F00D, n2);
    chk("post-rst cpu_ack", 32'(h_ack[n2 + 2]), 32'h1);
    chk("post-rst cpu_rdata", h_rdata[n2 + 2], 32'h0BAD_F00D);

    // Ack on the very cycle the counter reaches TIMEOUT.
    run_txn(32'h1000_0000, 32'h0, 4'h0, TMO, 1'b0, -1, 32'h7777_0001, n);
    chk("edge cpu_rdata", h_rdata[n + 9], 32'h7777_0001);
    chk("edge bus_error", 32'(h_err[n + 10]), 32'h0);
    idle(1);

    clr_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      idx = ($urandom_range(0, 4) == 0) ? $urandom_range(NDEV, 15) : $urandom_range(0, NDEV - 1);
      d   = $urandom_range(1, 12);
      ro  = -1;
      if (idx < NDEV && d > 1 && $urandom_range(0, 14) == 0) begin
        ro = $urandom_range(0, (d - 2 < TMO - 1) ? d - 2 : TMO - 1);
      end
      run_txn({4'(idx), 28'($urandom())}, $urandom(), 4'($urandom()), d,
              1'($urandom_range(0, 1)), ro, $urandom(), n);
      idle($urandom_range(0, 2));
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_router.md
CPU_BUS_ROUTER -- requirements
Module: cpu_bus_router

Interface
- REQ-001 SHALL have parameter NUM_DEVICES, default 4, number of device ports (1..16).
- REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for a device ack (1..255).
- REQ-003 SHALL have port sys.clk, input, 1, single clock; all logic on its rising edge.
- REQ-004 SHALL have port sys.reset, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port cpu_request, input, 1, one-cycle pulse starting a CPU access.
- REQ-006 SHALL have port cpu_address, input, 32, byte address, stable from the request until ack.
- REQ-007 SHALL have port cpu_wdata, input, 32, write data.
- REQ-008 SHALL have port cpu_wmask, input, 4, byte write enables; 0 means read.
- REQ-009 SHALL have port cpu_ack, output, 1, one-cycle completion pulse to CPU.
- REQ-010 SHALL have port cpu_rdata, output, 32, read data, valid only while cpu_ack=1, else 0.
- REQ-011 SHALL have port dev_request, output, NUM_DEVICES, per-device request pulse.
- REQ-012 SHALL have port dev_address / dev_wdata / dev_wmask, output, 32/32/4, shared to all devices.
- REQ-013 SHALL have port dev_ack, input, NUM_DEVICES, per-device ack.
- REQ-014 SHALL have port dev_rdata, input, 32*NUM_DEVICES, per-device read data, valid while that device's ack=1.
- REQ-015 SHALL have port bus_error, output, 1, sticky flag: unmapped access or timeout.
- REQ-016 SHALL have port bus_error_clear, input, 1, clears bus_error.

Function
- REQ-017 SHALL decode device index = cpu_address[31:28]; index >= NUM_DEVICES is unmapped.
- REQ-018 SHALL implement FSM states IDLE, WAIT, ERROR_ACK.
- REQ-019 IDLE + cpu_request + mapped index: SHALL latch the index, reset the timeout counter to 0, pulse dev_request[index] for exactly the next cycle, and enter WAIT.
- REQ-020 IDLE + cpu_request + unmapped index: SHALL enter ERROR_ACK without asserting any dev_request.
- REQ-021 ERROR_ACK: SHALL assert cpu_ack for one cycle with cpu_rdata=0, set bus_error, and return to IDLE.
- REQ-022 WAIT: SHALL pass dev_ack[latched] to cpu_ack and dev_rdata[latched] to cpu_rdata combinationally in the same cycle, then return to IDLE; acks from other devices are ignored.
- REQ-023 WAIT: SHALL increment the counter each cycle without ack; counter reaching TIMEOUT without ack SHALL, that cycle, pulse cpu_ack with cpu_rdata=32'hFFFF_FFFF, set bus_error, and return to IDLE.
- REQ-024 Ack arriving in the same cycle as the timeout SHALL take priority: normal data, no error.
- REQ-025 A late dev_ack after a timeout SHALL be ignored and produce no cpu_ack.
- REQ-026 cpu_request outside IDLE SHALL be ignored.
- REQ-027 Minimum latency SHALL be request at cycle N, dev_request at N+1, cpu_ack at N+2 for a device acking one cycle after its request.
- REQ-028 dev_address, dev_wdata and dev_wmask SHALL be registered copies of the CPU inputs latched on the accepted request and held until the next accepted request.
- REQ-029 bus_error_clear SHALL clear bus_error; a simultaneous set SHALL win.
- REQ-030 At most one dev_request bit SHALL be high in any cycle.

Reset
- REQ-031 sys.reset SHALL force IDLE and set cpu_ack=0, dev_request=0, bus_error=0, counter=0 and dev_address/wdata/wmask=0 on the next edge.
- REQ-032 Reset during WAIT SHALL abandon the transaction, and a subsequent dev_ack SHALL produce no cpu_ack.
- REQ-033 A cpu_request in a cycle with sys.reset=1 SHALL be dropped.

Verification
- REQ-034 Read of 0x1000_0004 with dev 1 acking one cycle after request, rdata 0x1234_5678 -> cpu_ack at N+2, cpu_rdata=0x1234_5678, dev_request=4'b0010 at N+1 only.
- REQ-035 Write 0x0000_0010, wdata 0xAABB_CCDD, wmask 4'hF -> dev_wdata=0xAABB_CCDD, dev_wmask=4'hF, dev_address=0x0000_0010 from N+1.
- REQ-036 Access to 0x5000_0000 with NUM_DEVICES=4 -> no dev_request, cpu_ack at N+2 with rdata 0, bus_error=1 until bus_error_clear.
- REQ-037 Device never acks, TIMEOUT=8 -> cpu_ack with 0xFFFF_FFFF and bus_error=1; a dev_ack injected 3 cycles later -> no cpu_ack.
- REQ-038 sys.reset pulsed in WAIT, then dev_ack -> no cpu_ack, all outputs 0; next request completes normally.
- REQ-039 dev_ack for a non-selected device during WAIT -> ignored, no cpu_ack.
